// File: rtl/wsacc_pkg.sv
// Shared defaults and types for the wsacc multi-channel weight-stationary PE.
package wsacc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int WIN_DEF    = 9;
  localparam int NCH_DEF    = 4;
  localparam int PROD_W_DEF = 2 * DATA_W_DEF + 1;

  // One channel's registered products at the default geometry.
  typedef logic [WIN_DEF*PROD_W_DEF-1:0] prod_row_t;

  function automatic int prod_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/wsacc_mac_lane.sv
// One output channel: WIN multipliers with S1 product register, then S2 summation register.
module wsacc_mac_lane
  import wsacc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int WIN    = WIN_DEF
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   load_s1,
  input  logic                   load_s2,
  input  logic                   act_unsigned,
  input  logic [WIN*DATA_W-1:0]  act,
  input  logic [WIN*DATA_W-1:0]  wts,
  output logic [ACC_W-1:0]       sum
);

  localparam int PW = prod_w(DATA_W);

  logic [PW-1:0]    prod_d [WIN];
  logic [PW-1:0]    prod_q [WIN];
  logic [ACC_W-1:0] sum_d;

  // Both operands are extended to the product width, so the truncated
  // unsigned product equals the signed one.
  for (genvar i = 0; i < WIN; i++) begin : g_mul
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] w;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     w_ext;
    assign a        = act[i*DATA_W +: DATA_W];
    assign w        = wts[i*DATA_W +: DATA_W];
    assign a_ext    = {{(DATA_W+1){a[DATA_W-1] & ~act_unsigned}}, a};
    assign w_ext    = {{(DATA_W+1){w[DATA_W-1]}}, w};
    assign prod_d[i] = a_ext * w_ext;
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      sum_d = sum_d + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < WIN; i++) begin
        prod_q[i] <= '0;
      end
      sum <= '0;
    end else begin
      if (load_s1) prod_q <= prod_d;
      if (load_s2) sum <= sum_d;
    end
  end

endmodule

// File: rtl/wsacc_pe_mc.sv
// Multi-channel weight-stationary PE: double-buffered weights, 3-stage MAC pipeline,
// multi-pass accumulation and valid/ready output with full-pipeline stall.
module wsacc_pe_mc
  import wsacc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int WIN    = WIN_DEF,
  parameter int NCH    = NCH_DEF
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wr_en,
  input  logic [$clog2(NCH)-1:0]   wr_ch,
  input  logic [$clog2(WIN)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     swap,
  input  logic                     act_unsigned,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIN*DATA_W-1:0]    in_data,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*ACC_W-1:0]     out_data
);

  if (ACC_W < 2*DATA_W + $clog2(WIN) + 1) begin : g_acc_w_check
    $error("wsacc_pe_mc: ACC_W too narrow for WIN products of DATA_W operands");
  end

  logic [DATA_W-1:0]     bank [2][NCH][WIN];
  logic                  bank_sel;
  logic                  write_ok;
  logic [WIN*DATA_W-1:0] lane_wts [NCH];
  logic [ACC_W-1:0]      lane_sum [NCH];
  logic [ACC_W-1:0]      acc [NCH];

  logic stall, advance, accept;
  logic s1_valid, s1_first, s1_last;
  logic s2_valid, s2_first, s2_last;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign write_ok = wr_en && (32'(wr_ch) < NCH) && (32'(wr_addr) < WIN);

  // Writes target the pre-edge shadow bank, so a write coinciding with swap
  // lands in the bank that becomes active.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          for (int unsigned i = 0; i < WIN; i++) begin
            bank[b][c][i] <= '0;
          end
        end
      end
      bank_sel <= 1'b0;
    end else begin
      if (write_ok) bank[~bank_sel][wr_ch][wr_addr] <= wr_data;
      if (swap) bank_sel <= ~bank_sel;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      lane_wts[c] = '0;
      for (int unsigned i = 0; i < WIN; i++) begin
        lane_wts[c][i*DATA_W +: DATA_W] = bank[bank_sel][c][i];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    wsacc_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .WIN    (WIN)
    ) u_lane (
      .clk          (clk),
      .nrst         (nrst),
      .load_s1      (accept),
      .load_s2      (advance),
      .act_unsigned (act_unsigned),
      .act          (in_data),
      .wts          (lane_wts[c]),
      .sum          (lane_sum[c])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        acc[c] <= '0;
      end
    end else if (advance) begin
      s1_valid  <= accept;
      s1_first  <= in_first;
      s1_last   <= in_last;
      s2_valid  <= s1_valid;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          acc[c] <= s2_first ? lane_sum[c] : acc[c] + lane_sum[c];
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      out_data[c*ACC_W +: ACC_W] = acc[c];
    end
  end

endmodule

// File: tb/tb_wsacc_pe_mc.sv
// Scoreboard bench for wsacc_pe_mc: a dot-product/accumulate reference model feeds an
// expected-result queue, and a monitor checks every output handshake.
module tb_wsacc_pe_mc;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int WIN    = 9;
  localparam int NCH    = 4;
  localparam int OW     = NCH * ACC_W;
  localparam int IW     = WIN * DATA_W;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_ch = '0;
  logic [3:0]        wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              swap = 1'b0;
  logic              act_unsigned = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW-1:0]     in_data = '0;
  logic              in_first = 1'b0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OW-1:0]     out_data;

  wsacc_pe_mc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .WIN(WIN), .NCH(NCH)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap         (swap),
    .act_unsigned (act_unsigned),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_first     (in_first),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

  logic [OW-1:0] sb [$];
  logic [OW-1:0] seen_q [$];

  // Reference model: active/shadow weight sets and per-channel running sums.
  int act_w [NCH][WIN];
  int shd_w [NCH][WIN];
  int m_acc [NCH];

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] vec4(input int a, input int b, input int c, input int d);
    logic [OW-1:0] r;
    r = {32'(d), 32'(c), 32'(b), 32'(a)};
    return r;
  endfunction

  function automatic logic [IW-1:0] fill(input int v);
    logic [IW-1:0] r;
    for (int i = 0; i < WIN; i++) r[i*DATA_W +: DATA_W] = 8'(v);
    return r;
  endfunction

  function automatic logic [IW-1:0] act0(input int v);
    logic [IW-1:0] r;
    r = '0;
    r[DATA_W-1:0] = 8'(v);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = 0;
      for (int i = 0; i < WIN; i++) begin
        act_w[c][i] = 0;
        shd_w[c][i] = 0;
      end
    end
    sb.delete();
    seen_q.delete();
  endtask

  // Applies one clock edge's worth of architectural effects, in the order
  // "beat uses pre-swap weights, write hits pre-swap shadow, then swap".
  task automatic model_edge(input logic took);
    int a;
    int dot;
    int tmp [NCH][WIN];
    logic [OW-1:0] r;
    if (took) begin
      for (int c = 0; c < NCH; c++) begin
        dot = 0;
        for (int i = 0; i < WIN; i++) begin
          a = act_unsigned ? int'(in_data[i*DATA_W +: DATA_W])
                           : int'($signed(in_data[i*DATA_W +: DATA_W]));
          dot += act_w[c][i] * a;
        end
        m_acc[c] = in_first ? dot : m_acc[c] + dot;
      end
      if (in_last) begin
        for (int c = 0; c < NCH; c++) r[c*ACC_W +: ACC_W] = 32'(m_acc[c]);
        sb.push_back(r);
      end
    end
    if (wr_en && int'(wr_addr) < WIN) shd_w[wr_ch][wr_addr] = int'($signed(wr_data));
    if (swap) begin
      tmp = act_w;
      act_w = shd_w;
      shd_w = tmp;
    end
  endtask

  task automatic tick();
    logic took;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b0;
    endcase
    @(negedge clk);
    took = in_valid && in_ready;
    @(posedge clk);
    if (nrst) model_edge(took);
    #1;
    wr_en = 1'b0;
    swap  = 1'b0;
    if (took) in_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input logic f, input logic l, input logic u);
    int n;
    n = 0;
    in_data = d; in_first = f; in_last = l; act_unsigned = u; in_valid = 1'b1;
    while (in_valid && n < 200) begin
      tick();
      n++;
    end
    if (in_valid) begin
      checks++; errors++;
      $display("FAIL accept_timeout waited=%0d cycles required=accept", n);
      in_valid = 1'b0;
    end
  endtask

  task automatic write_w(input int ch, input int addr, input int v);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_addr = 4'(addr); wr_data = 8'(v);
    tick();
  endtask

  task automatic load_ch(input int ch, input int v);
    for (int i = 0; i < WIN; i++) write_w(ch, i, v);
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    repeat (3) tick();
  endtask

  task automatic expect_seen(input string name, input logic [OW-1:0] exp);
    if (seen_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s got=none exp=%h", name, exp);
    end else begin
      check(name, seen_q.pop_front(), exp);
    end
  endtask

  // Monitor: compares each accepted output with the scoreboard and verifies
  // that a stalled output holds its value.
  logic [OW-1:0] prev_data = '0;
  logic          prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!nrst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", OW'(out_valid), OW'(1));
        check("stall_hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output got=%h exp=none", out_data);
        end else begin
          check("result", out_data, sb.pop_front());
        end
        seen_q.push_back(out_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [OW-1:0] snap;
    int n;
    logic [IW-1:0] d;

    model_reset();
    repeat (2) tick();
    check("rst_in_ready", OW'(in_ready), OW'(1));
    check("rst_out_valid", OW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    nrst = 1'b1;
    tick();

    // Basic dot product and 3-cycle latency
    load_ch(0, 1);
    load_ch(1, -1);
    do_swap();
    send_beat(fill(2), 1'b1, 1'b1, 1'b0);
    check("lat_cycle1", OW'(out_valid), '0);
    tick();
    check("lat_cycle2", OW'(out_valid), '0);
    tick();
    check("lat_cycle3", OW'(out_valid), OW'(1));
    drain();
    expect_seen("basic", vec4(18, -18, 0, 0));

    // Activation sign modes, back-to-back results with no bubble
    write_w(0, 0, -1);
    do_swap();
    send_beat(act0(8'hFF), 1'b1, 1'b1, 1'b1);
    send_beat(act0(8'hFF), 1'b1, 1'b1, 1'b0);
    tick();
    check("b2b_first_valid", OW'(out_valid), OW'(1));
    tick();
    check("b2b_second_valid", OW'(out_valid), OW'(1));
    drain();
    expect_seen("unsigned_ff", vec4(-255, 0, 0, 0));
    expect_seen("signed_ff", vec4(1, 0, 0, 0));

    write_w(0, 0, -128);
    do_swap();
    send_beat(act0(8'h80), 1'b1, 1'b1, 1'b0);
    drain();
    expect_seen("min_times_min", vec4(16384, 128, 0, 0));

    // Multi-pass accumulation
    load_ch(0, 1);
    do_swap();
    send_beat(act0(1), 1'b1, 1'b0, 1'b0);
    send_beat(act0(2), 1'b0, 1'b0, 1'b0);
    send_beat(act0(3), 1'b0, 1'b1, 1'b0);
    drain();
    expect_seen("accum", vec4(6, 0, 0, 0));
    check("accum_single_output", OW'(seen_q.size()), '0);

    // Backpressure
    rdy_mode = 2;
    send_beat(fill(1), 1'b1, 1'b1, 1'b0);
    send_beat(fill(2), 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_valid", OW'(out_valid), OW'(1));
    snap = out_data;
    repeat (5) begin
      tick();
      check("bp_in_ready", OW'(in_ready), '0);
      check("bp_data_stable", out_data, snap);
    end
    rdy_mode = 0;
    drain();
    expect_seen("bp_first", vec4(9, 0, 0, 0));
    expect_seen("bp_second", vec4(18, 0, 0, 0));
    check("bp_no_dup", OW'(seen_q.size()), '0);

    // Swap on the same cycle as an accepted beat and a shadow write
    load_ch(0, 2);
    wr_en = 1'b1; wr_ch = 2'd0; wr_addr = 4'd0; wr_data = 8'd5;
    swap = 1'b1;
    send_beat(fill(1), 1'b1, 1'b1, 1'b0);
    send_beat(fill(1), 1'b1, 1'b1, 1'b0);
    drain();
    expect_seen("swap_old_bank", vec4(9, 0, 0, 0));
    expect_seen("swap_new_bank", vec4(21, -9, 0, 0));

    // Reset after two of three beats
    send_beat(fill(1), 1'b1, 1'b0, 1'b0);
    send_beat(fill(1), 1'b0, 1'b0, 1'b0);
    nrst = 1'b0;
    #1;
    check("midrst_out_data", out_data, '0);
    check("midrst_in_ready", OW'(in_ready), OW'(1));
    check("midrst_out_valid", OW'(out_valid), '0);
    model_reset();
    tick();
    nrst = 1'b1;
    tick();
    load_ch(0, 1);
    do_swap();
    send_beat(fill(3), 1'b1, 1'b1, 1'b0);
    drain();
    expect_seen("post_reset", vec4(27, 0, 0, 0));

    // Random stream against the model
    rdy_mode = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(2) == 0) begin
        wr_en = 1'b1; wr_ch = 2'($urandom); wr_addr = 4'($urandom_range(15)); wr_data = 8'($urandom);
      end
      if ($urandom_range(7) == 0) swap = 1'b1;
      if ($urandom_range(3) != 0) begin
        for (int i = 0; i < WIN; i++) d[i*DATA_W +: DATA_W] = 8'($urandom);
        send_beat(d, $urandom_range(2) == 0, $urandom_range(1) == 0, $urandom_range(1) == 0);
      end else begin
        tick();
      end
    end
    rdy_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
